// File: rtl/if_id_stage_reg.sv
// IF/ID stage register with a 2-entry skid buffer (main + skid) feeding decode/extender.
// Splits the held instruction into register/immediate fields and counts flush-dropped entries.
module if_id_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] pc_o,
    output logic [4:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [11:0]       dataA_o,
    output logic [4:0]        dataB_o,
    output logic              ext_ctrl_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_instr_q, m_instr_d;
    logic [DATA_W-1:0] m_pc_q,    m_pc_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_instr_q, s_instr_d;
    logic [DATA_W-1:0] s_pc_q,    s_pc_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic             in_x;
    logic             out_x;
    logic [1:0]       drop_inc;
    logic [SUM_W-1:0] cnt_sum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_valid_q <= 1'b0;
            m_instr_q <= '0;
            m_pc_q    <= '0;
            s_valid_q <= 1'b0;
            s_instr_q <= '0;
            s_pc_q    <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_instr_q <= m_instr_d;
            m_pc_q    <= m_pc_d;
            s_valid_q <= s_valid_d;
            s_instr_q <= s_instr_d;
            s_pc_q    <= s_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Skid control: skid only ever holds the entry younger than main, so order is kept.
    always_comb begin
        m_valid_d = m_valid_q;
        m_instr_d = m_instr_q;
        m_pc_d    = m_pc_q;
        s_valid_d = s_valid_q;
        s_instr_d = s_instr_q;
        s_pc_d    = s_pc_q;
        cnt_d     = cnt_q;

        in_x     = in_valid_i & ~s_valid_q;
        out_x    = m_valid_q & out_ready_i;
        drop_inc = 2'(m_valid_q & ~out_x) + 2'(s_valid_q) + 2'(in_x);
        cnt_sum  = SUM_W'(cnt_q) + SUM_W'(drop_inc);

        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            cnt_d     = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : cnt_sum[CNT_W-1:0];
        end else if (!m_valid_q) begin
            if (in_x) begin
                m_valid_d = 1'b1;
                m_instr_d = instr_i;
                m_pc_d    = pc_i;
            end
        end else if (out_x) begin
            if (s_valid_q) begin
                m_instr_d = s_instr_q;
                m_pc_d    = s_pc_q;
                s_valid_d = 1'b0;
            end else if (in_x) begin
                m_instr_d = instr_i;
                m_pc_d    = pc_i;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (in_x) begin
            s_valid_d = 1'b1;
            s_instr_d = instr_i;
            s_pc_d    = pc_i;
        end
    end

    // Field slices of the main entry; sign extension belongs to the extender.
    assign in_ready_o  = ~s_valid_q;
    assign out_valid_o = m_valid_q;
    assign pc_o        = m_pc_q;
    assign opcode_o    = m_instr_q[31:27];
    assign dataB_o     = m_instr_q[26:22];
    assign rd_o        = m_instr_q[21:17];
    assign rs1_o       = m_instr_q[16:12];
    assign dataA_o     = m_instr_q[11:0];
    assign ext_ctrl_o  = (m_instr_q[31:30] == 2'b10);
    assign flush_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: table of hand-decoded instructions driven through a
// queue scoreboard, plus back-pressure, flush, saturation and async-reset sequences.
module tb_if_id_stage_reg;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [11:0] a;
        logic [4:0]  b;
        logic        ext;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o;
    logic [4:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [11:0] dataA_o;
    logic [4:0]  dataB_o;
    logic        ext_ctrl_o;
    logic [7:0]  flush_cnt_o;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    vec_t vecs[9];
    vec_t sb[$];

    if_id_stage_reg #(.DATA_W(32), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
        .opcode_o(opcode_o), .rd_o(rd_o), .rs1_o(rs1_o), .dataA_o(dataA_o),
        .dataB_o(dataB_o), .ext_ctrl_o(ext_ctrl_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive, check against the model before the edge, update model, clock.
    task automatic step(input logic iv, input vec_t v, input logic ordy, input logic fl);
        logic ox, ix, exp_ov, exp_ir;
        in_valid_i  = iv;
        instr_i     = v.instr;
        pc_i        = v.pc;
        out_ready_i = ordy;
        flush_i     = fl;
        #1;
        exp_ov = (sb.size() > 0);
        exp_ir = (sb.size() < 2);
        chk("out_valid", 32'(out_valid_o), 32'(exp_ov));
        chk("in_ready", 32'(in_ready_o), 32'(exp_ir));
        if (exp_ov) begin
            chk("pc_o", pc_o, sb[0].pc);
            chk("opcode", 32'(opcode_o), 32'(sb[0].op));
            chk("rd", 32'(rd_o), 32'(sb[0].rd));
            chk("rs1", 32'(rs1_o), 32'(sb[0].rs1));
            chk("dataA", 32'(dataA_o), 32'(sb[0].a));
            chk("dataB", 32'(dataB_o), 32'(sb[0].b));
            chk("ext_ctrl", 32'(ext_ctrl_o), 32'(sb[0].ext));
        end
        ox = exp_ov & ordy;
        ix = iv & exp_ir;
        if (ox) void'(sb.pop_front());
        if (fl) begin
            exp_cnt = exp_cnt + sb.size() + int'(ix);
            if (exp_cnt > 255) exp_cnt = 255;
            sb.delete();
        end else if (ix) begin
            sb.push_back(v);
        end
        @(posedge clk_i);
        #1;
        chk("flush_cnt", 32'(flush_cnt_o), 32'(exp_cnt));
    endtask

    function automatic vec_t with_pc(input vec_t v, input logic [31:0] pc);
        vec_t r = v;
        r.pc = pc;
        return r;
    endfunction

    initial begin
        //            instr         pc         op     rd     rs1    dataA    dataB  ext
        vecs[0] = '{32'h8FC0_1AAA, 32'h100, 5'h11, 5'h00, 5'h01, 12'hAAA, 5'h1F, 1'b1};
        vecs[1] = '{32'h0000_0000, 32'h104, 5'h00, 5'h00, 5'h00, 12'h000, 5'h00, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h108, 5'h1F, 5'h1F, 5'h1F, 12'hFFF, 5'h1F, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h10C, 5'h10, 5'h00, 5'h00, 12'h000, 5'h00, 1'b1};
        vecs[4] = '{32'h4000_0000, 32'h110, 5'h08, 5'h00, 5'h00, 12'h000, 5'h00, 1'b0};
        vecs[5] = '{32'h003E_0000, 32'h114, 5'h00, 5'h1F, 5'h00, 12'h000, 5'h00, 1'b0};
        vecs[6] = '{32'h0001_F000, 32'h118, 5'h00, 5'h00, 5'h1F, 12'h000, 5'h00, 1'b0};
        vecs[7] = '{32'h07C0_0000, 32'h11C, 5'h00, 5'h00, 5'h00, 12'h000, 5'h1F, 1'b0};
        vecs[8] = '{32'hA800_0000, 32'h120, 5'h15, 5'h00, 5'h00, 12'h000, 5'h00, 1'b1};

        rst_i = 1'b1; in_valid_i = 1'b0; instr_i = '0; pc_i = '0;
        out_ready_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid_o), 32'd0);
        chk("rst in_ready", 32'(in_ready_o), 32'd1);
        chk("rst dataA", 32'(dataA_o), 32'd0);
        chk("rst flush_cnt", 32'(flush_cnt_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Streaming pass-through of the whole table.
        for (int i = 0; i < 9; i++) step(1'b1, vecs[i], 1'b1, 1'b0);
        step(1'b0, vecs[0], 1'b1, 1'b0);
        step(1'b0, vecs[0], 1'b1, 1'b0);

        // Back-pressure: A, B fill main+skid, C refused, then drain in order.
        step(1'b1, with_pc(vecs[0], 32'h1000), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[2], 32'h1004), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[3], 32'h1008), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[3], 32'h1008), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, vecs[0], 1'b1, 1'b0);

        // Random valid/ready traffic.
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), with_pc(vecs[i % 9], 32'h2000 + 32'(i) * 4),
                 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, vecs[0], 1'b1, 1'b0);

        // Flush with main+skid full and input presented (refused: skid full).
        step(1'b1, with_pc(vecs[4], 32'h3000), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[5], 32'h3004), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[6], 32'h3008), 1'b0, 1'b1);
        step(1'b0, vecs[0], 1'b0, 1'b0);
        // Flush with main full, skid empty, incoming accepted, no drain: drops 2.
        step(1'b1, with_pc(vecs[7], 32'h3010), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[8], 32'h3014), 1'b0, 1'b1);
        // Flush with same-cycle delivery: delivered entry not counted, incoming is.
        step(1'b1, with_pc(vecs[1], 32'h3020), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[2], 32'h3024), 1'b1, 1'b1);
        step(1'b0, vecs[0], 1'b1, 1'b0);
        chk("flush total", 32'(flush_cnt_o), 32'd5);

        // Saturation: 300 single-entry flushes.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, with_pc(vecs[i % 9], 32'h4000 + 32'(i) * 4), 1'b0, 1'b0);
            step(1'b0, vecs[0], 1'b0, 1'b1);
        end
        chk("sat flush_cnt", 32'(flush_cnt_o), 32'd255);

        // Async reset mid back-pressure with main+skid full.
        step(1'b1, with_pc(vecs[0], 32'h5000), 1'b0, 1'b0);
        step(1'b1, with_pc(vecs[2], 32'h5004), 1'b0, 1'b0);
        #3 rst_i = 1'b1;
        #1;
        chk("arst out_valid", 32'(out_valid_o), 32'd0);
        chk("arst in_ready", 32'(in_ready_o), 32'd1);
        chk("arst flush_cnt", 32'(flush_cnt_o), 32'd0);
        chk("arst dataA", 32'(dataA_o), 32'd0);
        chk("arst pc_o", pc_o, 32'd0);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        step(1'b1, vecs[8], 1'b1, 1'b0);
        step(1'b0, vecs[0], 1'b1, 1'b0);
        step(1'b0, vecs[0], 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
